// File: rtl/axil_initiator_if.sv
// Bundle of the command/response port and the AXI4-Lite master port of axil_initiator.
// The master modport is the initiator's view; slave is the view of whatever sits around it.
interface axil_initiator_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;
    logic [STRB_WIDTH-1:0] cmd_wstrb;
    logic [2:0]            cmd_prot;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic [1:0]            rsp_resp;
    logic                  rsp_timeout;

    logic [ADDR_WIDTH-1:0] awaddr;
    logic [2:0]            awprot;
    logic                  awvalid;
    logic                  awready;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [2:0]            arprot;
    logic                  arvalid;
    logic                  arready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, cmd_prot, rsp_ready,
               awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_resp, rsp_timeout,
               awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, cmd_prot, rsp_ready,
               awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_resp, rsp_timeout,
               awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready
    );
endinterface

// File: rtl/axil_initiator.sv
// Single-outstanding AXI4-Lite master: turns one command into one AXI read or write,
// with optional local rejection of misaligned/empty-strobe commands and a response timeout.
module axil_initiator #(
    parameter int          ADDR_WIDTH     = 32,
    parameter int          DATA_WIDTH     = 32,
    parameter bit          ERR_RESP_EN    = 1'b0,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic             clk,
    input  logic             rst,
    axil_initiator_if.master bus
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int LSB_WIDTH  = $clog2(STRB_WIDTH);
    localparam int CNT_WIDTH  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST =
        CNT_WIDTH'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP} state_t;

    state_t                state_reg;
    logic                  cmd_ready_reg;
    logic                  awvalid_reg;
    logic                  wvalid_reg;
    logic                  arvalid_reg;
    logic                  bready_reg;
    logic                  rready_reg;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [DATA_WIDTH-1:0] wdata_reg;
    logic [STRB_WIDTH-1:0] wstrb_reg;
    logic [2:0]            prot_reg;
    logic                  rsp_valid_reg;
    logic [DATA_WIDTH-1:0] rsp_rdata_reg;
    logic [1:0]            rsp_resp_reg;
    logic                  rsp_timeout_reg;
    logic [CNT_WIDTH-1:0]  cnt_reg;

    logic cmd_fire;
    logic cmd_illegal;
    logic aw_done;
    logic w_done;
    logic timeout_hit;

    assign cmd_fire    = bus.cmd_valid && cmd_ready_reg;
    assign cmd_illegal = ERR_RESP_EN &&
                         ((|bus.cmd_addr[LSB_WIDTH-1:0]) ||
                          (bus.cmd_write && (bus.cmd_wstrb == '0)));
    // A channel counts as done once its valid has already dropped or it handshakes now.
    assign aw_done     = !awvalid_reg || bus.awready;
    assign w_done      = !wvalid_reg || bus.wready;
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_reg == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            cmd_ready_reg   <= 1'b0;
            awvalid_reg     <= 1'b0;
            wvalid_reg      <= 1'b0;
            arvalid_reg     <= 1'b0;
            bready_reg      <= 1'b0;
            rready_reg      <= 1'b0;
            addr_reg        <= '0;
            wdata_reg       <= '0;
            wstrb_reg       <= '0;
            prot_reg        <= '0;
            rsp_valid_reg   <= 1'b0;
            rsp_rdata_reg   <= '0;
            rsp_resp_reg    <= '0;
            rsp_timeout_reg <= 1'b0;
            cnt_reg         <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    cmd_ready_reg <= 1'b1;
                    if (cmd_fire) begin
                        cmd_ready_reg <= 1'b0;
                        addr_reg      <= bus.cmd_addr;
                        wdata_reg     <= bus.cmd_wdata;
                        wstrb_reg     <= bus.cmd_wstrb;
                        prot_reg      <= bus.cmd_prot;
                        if (cmd_illegal) begin
                            state_reg       <= RSP;
                            rsp_valid_reg   <= 1'b1;
                            rsp_rdata_reg   <= '0;
                            rsp_resp_reg    <= RESP_SLVERR;
                            rsp_timeout_reg <= 1'b0;
                        end else if (bus.cmd_write) begin
                            state_reg   <= WR_REQ;
                            awvalid_reg <= 1'b1;
                            wvalid_reg  <= 1'b1;
                        end else begin
                            state_reg   <= RD_REQ;
                            arvalid_reg <= 1'b1;
                        end
                    end
                end
                WR_REQ: begin
                    if (awvalid_reg && bus.awready) awvalid_reg <= 1'b0;
                    if (wvalid_reg && bus.wready)   wvalid_reg  <= 1'b0;
                    if (aw_done && w_done) begin
                        state_reg  <= WR_RESP;
                        bready_reg <= 1'b1;
                        cnt_reg    <= '0;
                    end
                end
                WR_RESP: begin
                    if (bus.bvalid) begin
                        state_reg       <= RSP;
                        bready_reg      <= 1'b0;
                        rsp_valid_reg   <= 1'b1;
                        rsp_rdata_reg   <= '0;
                        rsp_resp_reg    <= bus.bresp;
                        rsp_timeout_reg <= 1'b0;
                    end else if (timeout_hit) begin
                        state_reg       <= RSP;
                        bready_reg      <= 1'b0;
                        rsp_valid_reg   <= 1'b1;
                        rsp_rdata_reg   <= '0;
                        rsp_resp_reg    <= RESP_DECERR;
                        rsp_timeout_reg <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_WIDTH'(1);
                    end
                end
                RD_REQ: begin
                    if (bus.arready) begin
                        state_reg   <= RD_RESP;
                        arvalid_reg <= 1'b0;
                        rready_reg  <= 1'b1;
                        cnt_reg     <= '0;
                    end
                end
                RD_RESP: begin
                    // A response landing on the last counted cycle still wins over the timeout.
                    if (bus.rvalid) begin
                        state_reg       <= RSP;
                        rready_reg      <= 1'b0;
                        rsp_valid_reg   <= 1'b1;
                        rsp_rdata_reg   <= bus.rdata;
                        rsp_resp_reg    <= bus.rresp;
                        rsp_timeout_reg <= 1'b0;
                    end else if (timeout_hit) begin
                        state_reg       <= RSP;
                        rready_reg      <= 1'b0;
                        rsp_valid_reg   <= 1'b1;
                        rsp_rdata_reg   <= '0;
                        rsp_resp_reg    <= RESP_DECERR;
                        rsp_timeout_reg <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_WIDTH'(1);
                    end
                end
                RSP: begin
                    if (bus.rsp_ready) begin
                        state_reg     <= IDLE;
                        rsp_valid_reg <= 1'b0;
                        cmd_ready_reg <= 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.cmd_ready   = cmd_ready_reg;
    assign bus.rsp_valid   = rsp_valid_reg;
    assign bus.rsp_rdata   = rsp_rdata_reg;
    assign bus.rsp_resp    = rsp_resp_reg;
    assign bus.rsp_timeout = rsp_timeout_reg;
    assign bus.awaddr      = addr_reg;
    assign bus.awprot      = prot_reg;
    assign bus.awvalid     = awvalid_reg;
    assign bus.wdata       = wdata_reg;
    assign bus.wstrb       = wstrb_reg;
    assign bus.wvalid      = wvalid_reg;
    assign bus.bready      = bready_reg;
    assign bus.araddr      = addr_reg;
    assign bus.arprot      = prot_reg;
    assign bus.arvalid     = arvalid_reg;
    assign bus.rready      = rready_reg;
endmodule

// File: tb/tb_axil_initiator.sv
// Directed bench for axil_initiator (local error checks on, 8-cycle timeout): a vector table
// driven through a small cycle-based slave model, plus hand-written early-B and mid-transaction reset sequences.
module tb_axil_initiator;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_applied    = 0;
    int   n_miscompare = 0;

    always #5 clk = ~clk;

    axil_initiator_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    axil_initiator #(
        .ADDR_WIDTH    (32),
        .DATA_WIDTH    (32),
        .ERR_RESP_EN   (1'b1),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        bit          write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [2:0]  prot;
        int          a_dly;     // AW (writes) or AR (reads) ready delay
        int          w_dly;     // W ready delay
        int          r_dly;     // cycles from request done to B/R valid
        int          hold;      // cycles rsp_ready stays low after rsp_valid
        logic [1:0]  sresp;
        logic [31:0] srdata;
        bit          exp_bus;
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
        bit          exp_to;
        int          exp_lat;   // cycle of first rsp_valid, accept cycle = 0
    } vec_t;

    vec_t vecs [12];

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string what, input logic [63:0] act, input logic [63:0] exp);
        n_applied++;
        if (act !== exp) begin
            n_miscompare++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", what, act, exp);
        end
    endtask

    task automatic slave_idle();
        bus.awready = 1'b0; bus.wready = 1'b0; bus.arready = 1'b0;
        bus.bvalid  = 1'b0; bus.bresp  = 2'b00;
        bus.rvalid  = 1'b0; bus.rresp  = 2'b00; bus.rdata = '0;
        bus.rsp_ready = 1'b0;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!bus.cmd_ready && n < 20) begin
            tick();
            n++;
        end
        if (!bus.cmd_ready) chk("cmd_ready_wait", 0, 1);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int t, aw_hi, w_hi, ar_hi, b_hs, r_hs, viol, lat, hold_left, b_wait, r_wait, first_t;
        bit aw_done, w_done, ar_done, b_both, r_both, aw_f, w_f, ar_f, rsp_f, got, fin;
        logic [31:0] c_rdata;
        logic [1:0]  c_resp;
        logic        c_to;
        t = 0; aw_hi = 0; w_hi = 0; ar_hi = 0; b_hs = 0; r_hs = 0; viol = 0; lat = -1;
        hold_left = 0; b_wait = 0; r_wait = 0; first_t = -1;
        aw_done = 0; w_done = 0; ar_done = 0; got = 0; fin = 0;
        c_rdata = '0; c_resp = '0; c_to = 1'b0;
        wait_ready();
        bus.cmd_valid = 1'b1; bus.cmd_write = v.write; bus.cmd_addr = v.addr;
        bus.cmd_wdata = v.wdata; bus.cmd_wstrb = v.wstrb; bus.cmd_prot = v.prot;
        tick();
        t = 1;
        while (!fin && t < 40) begin
            // observe this cycle's outputs
            if (bus.cmd_ready) viol++;
            if ((bus.awvalid || bus.wvalid || bus.arvalid) && first_t < 0) first_t = t;
            if (t == 1 && v.write && v.exp_bus && !(bus.awvalid && bus.wvalid)) viol++;
            if (bus.awvalid) begin
                aw_hi++;
                if (aw_done || bus.awaddr !== v.addr || bus.awprot !== v.prot) viol++;
            end else if (aw_hi > 0 && !aw_done) viol++;
            if (bus.wvalid) begin
                w_hi++;
                if (w_done || bus.wdata !== v.wdata || bus.wstrb !== v.wstrb) viol++;
            end else if (w_hi > 0 && !w_done) viol++;
            if (bus.arvalid) begin
                ar_hi++;
                if (ar_done || bus.araddr !== v.addr || bus.arprot !== v.prot) viol++;
            end else if (ar_hi > 0 && !ar_done) viol++;
            b_both = aw_done && w_done;
            r_both = ar_done;
            if (bus.bready && !b_both) viol++;
            if (bus.rready && !r_both) viol++;
            if (bus.rsp_valid) begin
                if (!got) begin
                    got = 1; lat = t; hold_left = v.hold;
                    c_rdata = bus.rsp_rdata; c_resp = bus.rsp_resp; c_to = bus.rsp_timeout;
                end else if (bus.rsp_rdata !== c_rdata || bus.rsp_resp !== c_resp ||
                             bus.rsp_timeout !== c_to) viol++;
            end else if (got) viol++;
            // slave and response-side stimulus for this cycle
            bus.awready = bus.awvalid && (aw_hi - 1 >= v.a_dly);
            bus.wready  = bus.wvalid && (w_hi - 1 >= v.w_dly);
            bus.arready = bus.arvalid && (ar_hi - 1 >= v.a_dly);
            bus.bvalid  = b_both && (b_hs == 0) && (b_wait >= v.r_dly);
            bus.bresp   = bus.bvalid ? v.sresp : 2'b00;
            bus.rvalid  = r_both && (r_hs == 0) && (r_wait >= v.r_dly);
            bus.rresp   = bus.rvalid ? v.sresp : 2'b00;
            bus.rdata   = bus.rvalid ? v.srdata : 32'h0;
            bus.rsp_ready = got && (hold_left == 0);
            aw_f  = bus.awvalid && bus.awready;
            w_f   = bus.wvalid && bus.wready;
            ar_f  = bus.arvalid && bus.arready;
            rsp_f = bus.rsp_valid && bus.rsp_ready;
            if (bus.bvalid && bus.bready) b_hs++;
            if (bus.rvalid && bus.rready) r_hs++;
            tick();
            aw_done = aw_done || aw_f;
            w_done  = w_done || w_f;
            ar_done = ar_done || ar_f;
            if (b_both) b_wait++;
            if (r_both) r_wait++;
            if (got && hold_left > 0) hold_left--;
            fin = rsp_f;
            t++;
        end
        chk($sformatf("v%0d_rsp_seen", idx), got, 1);
        chk($sformatf("v%0d_cmd_ready_after", idx), bus.cmd_ready, 1);
        bus.cmd_valid = 1'b0;
        slave_idle();
        chk($sformatf("v%0d_latency", idx), lat, v.exp_lat);
        chk($sformatf("v%0d_resp", idx), c_resp, v.exp_resp);
        chk($sformatf("v%0d_rdata", idx), c_rdata, v.exp_rdata);
        chk($sformatf("v%0d_timeout", idx), c_to, v.exp_to);
        chk($sformatf("v%0d_protocol", idx), viol, 0);
        chk($sformatf("v%0d_aw_cycles", idx), aw_hi, (v.write && v.exp_bus) ? v.a_dly + 1 : 0);
        chk($sformatf("v%0d_w_cycles", idx), w_hi, (v.write && v.exp_bus) ? v.w_dly + 1 : 0);
        chk($sformatf("v%0d_ar_cycles", idx), ar_hi, (!v.write && v.exp_bus) ? v.a_dly + 1 : 0);
        chk($sformatf("v%0d_first_valid", idx), first_t, v.exp_bus ? 1 : -1);
        chk($sformatf("v%0d_resp_consumed", idx), b_hs + r_hs, (v.exp_bus && !v.exp_to) ? 1 : 0);
        $display("vec %0d: %s addr=0x%08h resp=%02b rdata=0x%08h timeout=%0b latency=%0d",
                 idx, v.write ? "WR" : "RD", v.addr, c_resp, c_rdata, c_to, lat);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //            wr addr      wdata         strb  prot    a w r  hold sresp  srdata        bus resp   exp_rdata     to lat
        vecs[0]  = '{1, 32'h10,  32'hDEADBEEF, 4'hF, 3'b000, 0, 0, 0,  0, 2'b00, 32'h0,        1, 2'b00, 32'h0,        0, 3};
        vecs[1]  = '{0, 32'h20,  32'h0,        4'hF, 3'b000, 3, 0, 0,  5, 2'b10, 32'h12345678, 1, 2'b10, 32'h12345678, 0, 6};
        vecs[2]  = '{1, 32'h40,  32'hA5A50F0F, 4'h3, 3'b010, 0, 3, 0,  0, 2'b00, 32'h0,        1, 2'b00, 32'h0,        0, 6};
        vecs[3]  = '{1, 32'h3,   32'h1,        4'hF, 3'b000, 0, 0, 0,  2, 2'b00, 32'h0,        0, 2'b10, 32'h0,        0, 1};
        vecs[4]  = '{1, 32'h8,   32'h2,        4'h0, 3'b000, 0, 0, 0,  0, 2'b00, 32'h0,        0, 2'b10, 32'h0,        0, 1};
        vecs[5]  = '{0, 32'h6,   32'h0,        4'hF, 3'b000, 0, 0, 0,  0, 2'b00, 32'hFFFFFFFF, 0, 2'b10, 32'h0,        0, 1};
        vecs[6]  = '{0, 32'h100, 32'h0,        4'h0, 3'b101, 0, 0, 2,  0, 2'b01, 32'hCAFEF00D, 1, 2'b01, 32'hCAFEF00D, 0, 5};
        vecs[7]  = '{1, 32'h104, 32'h01020304, 4'h8, 3'b001, 2, 0, 1,  0, 2'b11, 32'h0,        1, 2'b11, 32'h0,        0, 6};
        vecs[8]  = '{0, 32'h200, 32'h0,        4'hF, 3'b000, 0, 0, 99, 0, 2'b00, 32'h55,       1, 2'b11, 32'h0,        1, 10};
        vecs[9]  = '{1, 32'h204, 32'h77,       4'hF, 3'b000, 1, 1, 99, 0, 2'b00, 32'h0,        1, 2'b11, 32'h0,        1, 11};
        vecs[10] = '{0, 32'h208, 32'h0,        4'hF, 3'b000, 0, 0, 7,  0, 2'b00, 32'h87654321, 1, 2'b00, 32'h87654321, 0, 10};
        vecs[11] = '{0, 32'h20C, 32'h0,        4'hF, 3'b000, 0, 0, 8,  1, 2'b00, 32'hAAAA5555, 1, 2'b11, 32'h0,        1, 10};

        bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0;
        bus.cmd_wdata = '0;   bus.cmd_wstrb = '0;   bus.cmd_prot = '0;
        slave_idle();
        @(negedge clk);
        tick(); tick(); tick();
        chk("reset_cmd_ready",   bus.cmd_ready,   0);
        chk("reset_awvalid",     bus.awvalid,     0);
        chk("reset_wvalid",      bus.wvalid,      0);
        chk("reset_arvalid",     bus.arvalid,     0);
        chk("reset_bready",      bus.bready,      0);
        chk("reset_rready",      bus.rready,      0);
        chk("reset_rsp_valid",   bus.rsp_valid,   0);
        chk("reset_rsp_rdata",   bus.rsp_rdata,   0);
        chk("reset_rsp_resp",    bus.rsp_resp,    0);
        chk("reset_rsp_timeout", bus.rsp_timeout, 0);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

        // B already valid while W is still pending: it must wait for bready in WR_RESP.
        wait_ready();
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_addr = 32'h50;
        bus.cmd_wdata = 32'h11223344; bus.cmd_wstrb = 4'hF; bus.cmd_prot = 3'b000;
        bus.awready = 1'b1; bus.bvalid = 1'b1; bus.bresp = 2'b01;
        tick();
        bus.cmd_valid = 1'b0;
        chk("earlyb_t1_awvalid", bus.awvalid, 1);
        chk("earlyb_t1_wvalid",  bus.wvalid,  1);
        chk("earlyb_t1_bready",  bus.bready,  0);
        tick();
        chk("earlyb_t2_awvalid", bus.awvalid, 0);
        chk("earlyb_t2_wvalid",  bus.wvalid,  1);
        chk("earlyb_t2_bready",  bus.bready,  0);
        bus.wready = 1'b1;
        tick();
        chk("earlyb_t3_wvalid",  bus.wvalid,  0);
        chk("earlyb_t3_bready",  bus.bready,  1);
        bus.wready = 1'b0;
        tick();
        bus.bvalid = 1'b0;
        chk("earlyb_t4_rsp_valid", bus.rsp_valid,   1);
        chk("earlyb_t4_rsp_resp",  bus.rsp_resp,    2'b01);
        chk("earlyb_t4_timeout",   bus.rsp_timeout, 0);
        chk("earlyb_t4_bready",    bus.bready,      0);
        $display("seq early_b: WR addr=0x00000050 resp=%02b timeout=%0b", bus.rsp_resp, bus.rsp_timeout);
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;

        // Reset in the middle of a read abandons it without a response.
        wait_ready();
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 32'h60; bus.cmd_prot = 3'b000;
        tick();
        bus.cmd_valid = 1'b0;
        tick(); tick();
        chk("midrst_arvalid_before", bus.arvalid, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_arvalid_after",  bus.arvalid,   0);
        chk("midrst_rsp_valid",      bus.rsp_valid, 0);
        chk("midrst_cmd_ready",      bus.cmd_ready, 0);
        $display("seq mid_reset: RD addr=0x00000060 abandoned, arvalid=%0b", bus.arvalid);
        run_vec(12, vecs[0]);

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscompare);
        $finish;
    end
endmodule
